// File: rtl/axis_chk_pkg.sv
// Shared types and helpers for the AXI-Stream frame checker.
// Helpers operate on 32-bit values; callers cast to their own widths (widths up to 32).
package axis_chk_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  // A programmed length of zero means single-beat frames.
  function automatic logic [31:0] eff_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] inc,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, v} + {1'b0, inc};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/axis_ready_shaper.sv
// Rotating tready pattern generator; tready is a flop output, never a function of tvalid.
module axis_ready_shaper #(
  parameter int PATTERN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic [PATTERN_W-1:0] pattern,
  output logic                 tready
);

  logic [PATTERN_W-1:0] pat_eff;
  logic [PATTERN_W-1:0] pattern_reg;

  // An all-zero pattern would deadlock the stream, so it means "always ready".
  assign pat_eff = (pattern == '0) ? '1 : pattern;

  function automatic logic [PATTERN_W-1:0] rotr(input logic [PATTERN_W-1:0] p);
    return (p >> 1) | (p << (PATTERN_W - 1));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_reg <= '0;
      tready      <= 1'b0;
    end else if (load) begin
      tready      <= pat_eff[0];
      pattern_reg <= rotr(pat_eff);
    end else if (advance) begin
      tready      <= pattern_reg[0];
      pattern_reg <= rotr(pattern_reg);
    end else begin
      tready      <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream sink: shapes tready, checks incrementing payload and frame length, counts frames/errors.
module axis_frame_checker
  import axis_chk_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int PATTERN_W   = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  cfg_enable,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [PATTERN_W-1:0]  cfg_ready_pattern,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_data,
  output logic                  err_len,
  output logic                  halted
);

  localparam logic [LEN_WIDTH-1:0] IDX_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [LEN_WIDTH-1:0]  last_idx;
  logic [LEN_WIDTH-1:0]  beat_idx;
  logic                  len_flagged;
  logic                  accept, data_bad, len_bad, load, advance;

  assign accept  = (state == RUN) && s_axis_tvalid && s_axis_tready;
  assign load    = (state == IDLE) && (state_nx == RUN);
  assign advance = (state == RUN) && (state_nx == RUN);
  assign halted  = (state == HALT);

  always_comb begin
    data_bad = 1'b0;
    len_bad  = 1'b0;
    state_nx = state;
    if (accept) begin
      data_bad = (s_axis_tdata != exp_data);
      if (s_axis_tlast) len_bad = (beat_idx != last_idx);
      else              len_bad = (beat_idx == last_idx) && !len_flagged;
    end
    case (state)
      IDLE: if (cfg_enable) state_nx = RUN;
      // Disable wins over a simultaneous error.
      RUN: begin
        if (!cfg_enable)                              state_nx = IDLE;
        else if (STOP_ON_ERR && (data_bad || len_bad)) state_nx = HALT;
      end
      HALT: if (!cfg_enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      exp_data    <= '0;
      last_idx    <= '0;
      beat_idx    <= '0;
      len_flagged <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
      err_data    <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      state    <= state_nx;
      err_data <= data_bad;
      err_len  <= len_bad;
      err_count <= CNT_WIDTH'(sat_add(32'(err_count), 32'(data_bad) + 32'(len_bad),
                                      32'(CNT_MAX)));
      if (load) begin
        exp_data    <= cfg_seed;
        last_idx    <= LEN_WIDTH'(eff_len(32'(cfg_frame_len)) - 32'd1);
        beat_idx    <= '0;
        len_flagged <= 1'b0;
      end else if (accept) begin
        // Follow the received data so a single bad beat doesn't cascade.
        exp_data <= s_axis_tdata + DATA_WIDTH'(1);
        if (s_axis_tlast) begin
          beat_idx    <= '0;
          len_flagged <= 1'b0;
          frame_count <= CNT_WIDTH'(sat_add(32'(frame_count), 32'd1, 32'(CNT_MAX)));
        end else begin
          beat_idx <= LEN_WIDTH'(sat_add(32'(beat_idx), 32'd1, 32'(IDX_MAX)));
          if (len_bad) len_flagged <= 1'b1;
        end
      end
    end
  end

  axis_ready_shaper #(.PATTERN_W(PATTERN_W)) u_shaper (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .pattern (cfg_ready_pattern),
    .tready  (s_axis_tready)
  );

endmodule

// File: tb/tb_axis_frame_checker.sv
// Directed bench for axis_frame_checker: table of per-beat vectors plus hand sequences.
module tb_axis_frame_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast;
  logic        cfg_enable;
  logic [31:0] cfg_seed;
  logic [15:0] cfg_frame_len;
  logic [7:0]  cfg_ready_pattern;

  logic        tready0, ed0, el0, h0;
  logic [15:0] fc0, ec0;
  logic        tready1, ed1, el1, h1;
  logic [15:0] fc1, ec1;

  always #5 clk = ~clk;

  axis_frame_checker #(.STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(tready0), .cfg_enable(cfg_enable),
    .cfg_seed(cfg_seed), .cfg_frame_len(cfg_frame_len), .cfg_ready_pattern(cfg_ready_pattern),
    .frame_count(fc0), .err_count(ec0), .err_data(ed0), .err_len(el0), .halted(h0)
  );

  axis_frame_checker #(.STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(tready1), .cfg_enable(cfg_enable),
    .cfg_seed(cfg_seed), .cfg_frame_len(cfg_frame_len), .cfg_ready_pattern(cfg_ready_pattern),
    .frame_count(fc1), .err_count(ec1), .err_data(ed1), .err_len(el1), .halted(h1)
  );

  typedef struct {int t; logic [31:0] d; logic l; logic ed; logic el;} vec_t;
  typedef struct {logic [31:0] seed; logic [15:0] len; int fc; int ec;} cfg_t;

  vec_t vecs[$];
  cfg_t cfgs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic av(input int t, input logic [31:0] d, input logic l, input logic ed,
                    input logic el);
    vecs.push_back('{t, d, l, ed, el});
  endtask

  task automatic ac(input logic [31:0] seed, input logic [15:0] len, input int fc, input int ec);
    cfgs.push_back('{seed, len, fc, ec});
  endtask

  // Reset, program, enable; returns #1 after the IDLE->RUN edge.
  task automatic start(input logic [31:0] seed, input logic [15:0] len, input logic [7:0] pat);
    rst = 1'b1; cfg_enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; cfg_seed = seed; cfg_frame_len = len; cfg_ready_pattern = pat;
    cfg_enable = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int first, lastc, errs, rdy_bad;
    logic rdy, done;

    rst = 1'b1; cfg_enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; cfg_seed = '0; cfg_frame_len = '0; cfg_ready_pattern = '0;
    @(posedge clk); #1;
    check("reset_tready", tready0, 0);
    check("reset_fc", fc0, 0);
    check("reset_ec", ec0, 0);
    check("reset_pulses", {ed0, el0, h0}, 0);

    // t0: clean frame
    ac(32'd1, 16'd6, 1, 0);
    for (int i = 1; i <= 6; i++) av(0, i, i == 6, 0, 0);
    // t1: data jump 2 -> 7, resync afterwards
    ac(32'd1, 16'd6, 1, 1);
    av(1, 1, 0, 0, 0); av(1, 2, 0, 0, 0); av(1, 7, 0, 1, 0);
    av(1, 8, 0, 0, 0); av(1, 9, 0, 0, 0); av(1, 10, 1, 0, 0);
    // t2: early tlast, then a clean frame shows the index restarted at 0
    ac(32'd10, 16'd6, 2, 1);
    av(2, 10, 0, 0, 0); av(2, 11, 0, 0, 0); av(2, 12, 1, 0, 1);
    for (int i = 13; i <= 18; i++) av(2, i, i == 18, 0, 0);
    // t3: data wraps through zero
    ac(32'hFFFF_FFFE, 16'd4, 1, 0);
    av(3, 32'hFFFF_FFFE, 0, 0, 0); av(3, 32'hFFFF_FFFF, 0, 0, 0);
    av(3, 0, 0, 0, 0); av(3, 1, 1, 0, 0);
    // t4: length 0 behaves as length 1
    ac(32'd5, 16'd0, 2, 0);
    av(4, 5, 1, 0, 0); av(4, 6, 1, 0, 0);
    // t5: missing tlast flagged once, then the late tlast is misplaced
    ac(32'd1, 16'd2, 1, 2);
    av(5, 1, 0, 0, 0); av(5, 2, 0, 0, 1); av(5, 3, 0, 0, 0); av(5, 4, 1, 0, 1);
    // t6: one beat carrying both errors counts twice
    ac(32'd1, 16'd2, 1, 2);
    av(6, 5, 1, 1, 1);

    foreach (cfgs[t]) begin
      start(cfgs[t].seed, cfgs[t].len, 8'hFF);
      foreach (vecs[i]) begin
        if (vecs[i].t == t) begin
          s_axis_tdata = vecs[i].d; s_axis_tvalid = 1'b1; s_axis_tlast = vecs[i].l;
          check($sformatf("t%0d_v%0d_tready", t, i), tready0, 1);
          @(posedge clk); #1;
          check($sformatf("t%0d_v%0d_err_data", t, i), ed0, vecs[i].ed);
          check($sformatf("t%0d_v%0d_err_len", t, i), el0, vecs[i].el);
        end
      end
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      check($sformatf("t%0d_frame_count", t), fc0, cfgs[t].fc);
      check($sformatf("t%0d_err_count", t), ec0, cfgs[t].ec);
    end

    // Sparse ready: bits 0 and 2 of each 8 -> accepts at offsets 0,2,8,10,16,18.
    pat = 8'b0000_0101;
    start(32'd1, 16'd6, pat);
    s_axis_tdata = 32'd1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    first = -1; lastc = -1; errs = 0; rdy_bad = 0; done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      rdy = tready0;
      if (rdy !== pat[cyc % 8]) rdy_bad++;
      @(posedge clk); #1;
      if (ed0 || el0) errs++;
      if (rdy) begin
        if (first < 0) first = cyc;
        if (s_axis_tdata == 32'd6) begin
          lastc = cyc; done = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        end else begin
          s_axis_tdata = s_axis_tdata + 32'd1;
          s_axis_tlast = (s_axis_tdata == 32'd6);
        end
      end
    end
    check("sparse_done", done, 1);
    check("sparse_first", first, 0);
    check("sparse_span", lastc - first, 18);
    check("sparse_tready_pattern", rdy_bad, 0);
    check("sparse_errs", errs, 0);
    check("sparse_fc", fc0, 1);
    check("sparse_ec", ec0, 0);
    cfg_enable = 1'b0;
    @(posedge clk); #1;
    check("disable_tready", tready0, 0);

    // Halt on error, then reset mid-frame (STOP_ON_ERR instance).
    start(32'd1, 16'd6, 8'hFF);
    s_axis_tdata = 32'd1; s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    check("halt_ok_beat", {ed1, h1}, 0);
    s_axis_tdata = 32'd9;
    @(posedge clk); #1;
    check("halt_err_data", ed1, 1);
    check("halt_halted", h1, 1);
    check("halt_tready", tready1, 0);
    check("halt_ec", ec1, 1);
    s_axis_tdata = 32'd10;
    @(posedge clk); #1;
    check("halt_no_accept_ec", ec1, 1);
    check("halt_pulse_cleared", ed1, 0);
    check("halt_still", h1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_halted", h1, 0);
    check("rst_tready", tready1, 0);
    check("rst_ec", ec1, 0);
    check("rst_fc", fc1, 0);
    check("rst_pulses", {ed1, el1}, 0);
    rst = 1'b0; s_axis_tvalid = 1'b0; cfg_enable = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
